// File: rtl/abp_pkg.sv
// abp_pkg: shared state encoding and default sizing for the ABP sequencer.
package abp_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} abp_seq_state_t;
  localparam int ABP_VALUE_SIZE = 4;
endpackage

// File: rtl/abp_timeout_timer.sv
// abp_timeout_timer: ack-wait cycle counter; expired flags the final cycle of the wait window.
module abp_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic aclk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  always_ff @(posedge aclk)
    if (!resetn || clear) cnt <= '0;
    else if (run) cnt <= cnt + W'(1);
  assign expired = run && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/abp_seq_ctrl.sv
// abp_seq_ctrl: alternating-bit sequencer; statistics counters built only with ABP_SEQ_CTRL_STATS_EN.
module abp_seq_ctrl
  import abp_pkg::*;
#(
  parameter int VALUE_SIZE     = ABP_VALUE_SIZE,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    s_rx_valid,
  input  logic [8*VALUE_SIZE-1:0] s_rx_value,
  input  logic                    s_rx_bit,
  output logic                    m_abp_valid,
  input  logic                    m_abp_ready,
  output logic [8*VALUE_SIZE-1:0] m_abp_value,
  output logic                    m_abp_bit,
  output logic                    busy,
  output logic                    timeout_pulse,
  output logic [15:0]             ack_count,
  output logic [15:0]             timeout_count,
  output logic [15:0]             discard_count
);
  abp_seq_state_t state;
  logic waiting, expired, ack_hit, to_hit;
  assign waiting = state == WAIT_ACK;
  assign ack_hit = waiting && enable && s_rx_valid && s_rx_bit == m_abp_bit;
  // An ack landing on the expiry cycle suppresses the timeout.
  assign to_hit  = waiting && enable && !ack_hit && expired;
  abp_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .aclk    (aclk),
    .resetn  (resetn),
    .clear   (!waiting),
    .run     (waiting),
    .expired (expired)
  );
  always_ff @(posedge aclk)
    if (!resetn) begin
      state         <= IDLE;
      m_abp_valid   <= 1'b0;
      m_abp_value   <= '0;
      m_abp_bit     <= 1'b0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE:
          if (enable) begin
            state       <= ISSUE;
            m_abp_valid <= 1'b1;
            m_abp_value <= '0;
            m_abp_bit   <= 1'b0;
            busy        <= 1'b1;
          end
        ISSUE:
          if (m_abp_valid && m_abp_ready) begin
            m_abp_valid <= 1'b0;
            state       <= enable ? WAIT_ACK : IDLE;
            busy        <= enable;
          end
        WAIT_ACK:
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (ack_hit) begin
            m_abp_value <= s_rx_value;
            m_abp_bit   <= ~m_abp_bit;
            m_abp_valid <= 1'b1;
            state       <= ISSUE;
          end else if (to_hit) begin
            timeout_pulse <= 1'b1;
            m_abp_valid   <= 1'b1;
            state         <= ISSUE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef ABP_SEQ_CTRL_STATS_EN
  logic disc_hit;
  assign disc_hit = waiting && enable && s_rx_valid && s_rx_bit != m_abp_bit;
  always_ff @(posedge aclk)
    if (!resetn) begin
      ack_count     <= '0;
      timeout_count <= '0;
      discard_count <= '0;
    end else begin
      if (ack_hit && ack_count != 16'hFFFF) ack_count <= ack_count + 16'd1;
      if (to_hit && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
      if (disc_hit && discard_count != 16'hFFFF) discard_count <= discard_count + 16'd1;
    end
`else
  assign ack_count     = '0;
  assign timeout_count = '0;
  assign discard_count = '0;
`endif
endmodule

// File: tb/tb_abp_seq_ctrl.sv
// tb_abp_seq_ctrl: directed scoreboard bench for abp_seq_ctrl with TIMEOUT_CYCLES=16.
module tb_abp_seq_ctrl;
  logic        aclk = 1'b0, resetn = 1'b0, enable = 1'b0;
  logic        s_rx_valid = 1'b0, s_rx_bit = 1'b0, m_abp_ready = 1'b0;
  logic [31:0] s_rx_value = '0;
  logic        m_abp_valid, m_abp_bit, busy, timeout_pulse;
  logic [31:0] m_abp_value;
  logic [15:0] ack_count, timeout_count, discard_count;
  int n_chk = 0, n_fail = 0, s;
  logic [32:0] exp_q[$];

  abp_seq_ctrl #(.VALUE_SIZE(4), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .resetn(resetn), .enable(enable),
    .s_rx_valid(s_rx_valid), .s_rx_value(s_rx_value), .s_rx_bit(s_rx_bit),
    .m_abp_valid(m_abp_valid), .m_abp_ready(m_abp_ready),
    .m_abp_value(m_abp_value), .m_abp_bit(m_abp_bit),
    .busy(busy), .timeout_pulse(timeout_pulse),
    .ack_count(ack_count), .timeout_count(timeout_count), .discard_count(discard_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ec(input int n);
`ifdef ABP_SEQ_CTRL_STATS_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_timeout(output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (!timeout_pulse && steps < 40);
    chk("timeout_seen", {31'd0, timeout_pulse}, 32'd1);
  endtask

  // Monitor: every accepted transfer must match the oldest expected one.
  always @(negedge aclk)
    if (resetn && m_abp_valid && m_abp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL hs_unexpected: got value %0h bit %0b, expected no transfer", m_abp_value, m_abp_bit);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("hs_value", m_abp_value, e[31:0]);
        chk("hs_bit", {31'd0, m_abp_bit}, {31'd0, e[32]});
      end
    end

  initial begin
    step();
    step();
    resetn = 1'b1;
    chk("rst_valid", {31'd0, m_abp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_value", m_abp_value, 32'd0);
    chk("rst_pulse", {31'd0, timeout_pulse}, 32'd0);
    chk("rst_ack_cnt", {16'd0, ack_count}, 32'd0);
    // startup
    exp_q.push_back({1'b0, 32'h0});
    enable = 1'b1;
    m_abp_ready = 1'b1;
    step();
    chk("start_valid", {31'd0, m_abp_valid}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    step();
    chk("start_hs_drop", {31'd0, m_abp_valid}, 32'd0);
    chk("start_wait_busy", {31'd0, busy}, 32'd1);
    // matching ack
    exp_q.push_back({1'b1, 32'h1});
    s_rx_valid = 1'b1; s_rx_value = 32'h1; s_rx_bit = 1'b0;
    step();
    s_rx_valid = 1'b0;
    chk("ack_valid", {31'd0, m_abp_valid}, 32'd1);
    chk("ack_value", m_abp_value, 32'h1);
    chk("ack_bit", {31'd0, m_abp_bit}, 32'd1);
    chk("ack_cnt1", {16'd0, ack_count}, {16'd0, ec(1)});
    step();
    // three timeouts, same value and bit reissued
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 32'h1});
      wait_timeout(s);
      chk("timeout_cycles", s, 16);
      chk("timeout_reissue_valid", {31'd0, m_abp_valid}, 32'd1);
      chk("timeout_reissue_value", m_abp_value, 32'h1);
      chk("timeout_reissue_bit", {31'd0, m_abp_bit}, 32'd1);
      chk("timeout_cnt", {16'd0, timeout_count}, {16'd0, ec(i + 1)});
      step();
      chk("pulse_one_shot", {31'd0, timeout_pulse}, 32'd0);
      chk("timeout_hs_drop", {31'd0, m_abp_valid}, 32'd0);
    end
    // stale ack at timer=5
    repeat (5) step();
    s_rx_valid = 1'b1; s_rx_value = 32'hDEAD; s_rx_bit = 1'b0;
    step();
    s_rx_valid = 1'b0;
    chk("stale_discard_cnt", {16'd0, discard_count}, {16'd0, ec(1)});
    chk("stale_stays_wait", {31'd0, m_abp_valid}, 32'd0);
    chk("stale_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back({1'b1, 32'h1});
    wait_timeout(s);
    chk("stale_timeout_cycles", s + 6, 16);
    chk("stale_value_kept", m_abp_value, 32'h1);
    chk("stale_timeout_cnt", {16'd0, timeout_count}, {16'd0, ec(4)});
    step();
    // ack on the expiry cycle, then backpressure
    m_abp_ready = 1'b0;
    repeat (15) step();
    s_rx_valid = 1'b1; s_rx_value = 32'h12345678; s_rx_bit = 1'b1;
    step();
    s_rx_value = 32'hAAAA; s_rx_bit = 1'b0;
    chk("coll_no_pulse", {31'd0, timeout_pulse}, 32'd0);
    chk("coll_value", m_abp_value, 32'h12345678);
    chk("coll_bit", {31'd0, m_abp_bit}, 32'd0);
    chk("coll_ack_cnt", {16'd0, ack_count}, {16'd0, ec(2)});
    chk("coll_timeout_cnt", {16'd0, timeout_count}, {16'd0, ec(4)});
    for (int i = 0; i < 10; i++) begin
      step();
      s_rx_valid = 1'b0;
      chk("bp_valid", {31'd0, m_abp_valid}, 32'd1);
      chk("bp_value", m_abp_value, 32'h12345678);
      chk("bp_bit", {31'd0, m_abp_bit}, 32'd0);
    end
    chk("bp_rx_ignored", {16'd0, ack_count}, {16'd0, ec(2)});
    exp_q.push_back({1'b0, 32'h12345678});
    m_abp_ready = 1'b1;
    step();
    chk("bp_hs_drop", {31'd0, m_abp_valid}, 32'd0);
    // disable in WAIT_ACK
    enable = 1'b0;
    step();
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_valid", {31'd0, m_abp_valid}, 32'd0);
    // reset while issuing
    m_abp_ready = 1'b0;
    enable = 1'b1;
    step();
    chk("reissue_valid", {31'd0, m_abp_valid}, 32'd1);
    m_abp_ready = 1'b1;
    resetn = 1'b0;
    step();
    chk("mid_rst_valid", {31'd0, m_abp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_value", m_abp_value, 32'd0);
    chk("mid_rst_bit", {31'd0, m_abp_bit}, 32'd0);
    chk("mid_rst_pulse", {31'd0, timeout_pulse}, 32'd0);
    chk("mid_rst_cnts", {ack_count, timeout_count | discard_count}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/abp_seq_ctrl.md
ABP_SEQ_CTRL -- requirements
Module: abp_seq_ctrl

Interface
REQ-001 SHALL have parameter VALUE_SIZE, default 4, meaning bytes in the ABP sequence value.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning ack-wait cycles before retransmit (minimum 2).
REQ-003 SHALL have ports: aclk  input  1  clock; resetn  input  1  reset. Reset resetn is synchronous and active-low; the clock is aclk.
REQ-004 SHALL have port enable  input  1  run request for the sequencer.
REQ-005 SHALL have ports s_rx_valid  input  1, s_rx_value  input  8*VALUE_SIZE, s_rx_bit  input  1: single-cycle received-packet hyperdata; always accepted, no ready.
REQ-006 SHALL have ports m_abp_valid  output  1, m_abp_ready  input  1, m_abp_value  output  8*VALUE_SIZE, m_abp_bit  output  1: hyperdata to the packet transmitter.
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port timeout_pulse  output  1  one-cycle strobe on each timeout.
REQ-009 SHALL have ports ack_count, timeout_count, discard_count  output  16 each  statistics.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT_ACK; all outputs registered.
REQ-011 IDLE: when enable=1, SHALL load cur_value=0 and cur_bit=0 and enter ISSUE; m_abp_valid SHALL be high on the next cycle.
REQ-012 ISSUE: SHALL hold m_abp_valid=1 with m_abp_value=cur_value and m_abp_bit=cur_bit stable until m_abp_valid&&m_abp_ready; valid SHALL NOT drop before the handshake.
REQ-013 On the handshake cycle, SHALL deassert m_abp_valid, clear the timer, and enter WAIT_ACK, or IDLE if enable=0.
REQ-014 WAIT_ACK: the timer SHALL increment by 1 each cycle; s_rx_valid with s_rx_bit==cur_bit SHALL count as an ack.
REQ-015 On an ack, SHALL set cur_value=s_rx_value and cur_bit=~cur_bit, increment ack_count, and enter ISSUE; m_abp_valid SHALL rise the following cycle.
REQ-016 SHALL discard s_rx_valid with s_rx_bit!=cur_bit in WAIT_ACK, increment discard_count, and neither change state nor reset the timer.
REQ-017 When the timer reaches TIMEOUT_CYCLES-1 with no ack, SHALL pulse timeout_pulse, increment timeout_count, and re-enter ISSUE with cur_value and cur_bit unchanged.
REQ-018 If an ack and a timeout occur in the same cycle, the ack SHALL win: no timeout_pulse and no timeout_count increment.
REQ-019 SHALL ignore s_rx_valid in IDLE and ISSUE, with no counter change.
REQ-020 enable=0 in WAIT_ACK SHALL move to IDLE on the next cycle; enable=0 in ISSUE SHALL take effect only after the handshake (REQ-013).
REQ-021 All counters SHALL saturate at 16'hFFFF; value arithmetic is pass-through, with no increment inside this block.
REQ-022 The timer width SHALL be $clog2(TIMEOUT_CYCLES).

Reset
REQ-023 While resetn=0 at a clock edge: state=IDLE; m_abp_valid=0; m_abp_value=0; m_abp_bit=0; busy=0; timeout_pulse=0; all counters and the timer =0.
REQ-024 Reset asserted mid-handshake SHALL drop m_abp_valid on the following edge regardless of m_abp_ready.

Configuration
REQ-025 Macro ABP_SEQ_CTRL_STATS_EN defined: ack_count, timeout_count and discard_count SHALL behave per REQ-015 to REQ-017 and REQ-021.
REQ-026 Macro ABP_SEQ_CTRL_STATS_EN undefined: the three counter outputs SHALL be constant 0 with no counter registers; all other behaviour is unchanged.

Structure
REQ-027 Package abp_pkg SHALL hold the state enum typedef (abp_seq_state_t) and the default VALUE_SIZE constant.
REQ-028 The timeout counter SHALL be sub-module abp_timeout_timer (inputs clear and run; output expired), instantiated once.

Verification (TIMEOUT_CYCLES=16 in the bench)
REQ-029 Bench SHALL cover startup: reset, then enable=1 and m_abp_ready=1 -> one handshake with value 0x00000000, bit 0; busy=1.
REQ-030 Bench SHALL cover a matching ack: rx value 0x00000001, bit 0, in WAIT_ACK -> the next cycle has m_abp_valid=1, value 0x00000001, bit 1; ack_count=1.
REQ-031 Bench SHALL cover timeout: no rx for 16 cycles -> one timeout_pulse, the same value and bit reissued, timeout_count=1; repeat 3 times -> timeout_count=3.
REQ-032 Bench SHALL cover a stale ack: rx with bit!=cur_bit at timer=5 -> discard_count=1, state stays WAIT_ACK, timeout still at timer=15.
REQ-033 Bench SHALL cover backpressure and a collision: m_abp_ready=0 for 10 cycles -> valid and data stable; ack on the expiry cycle -> no timeout_pulse, bit toggles.
REQ-034 Bench SHALL cover mid-operation disable and reset: enable=0 in WAIT_ACK -> IDLE next cycle, busy=0; resetn=0 during ISSUE -> all outputs 0 after the edge.
